// File: rtl/adpcm_sample_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : adpcm_sample_sequencer
//  Brief    : Per-sample five-stage scheduler for the ADPCM datapath, with
//             per-stage watchdog, overrun/timeout flags and a sample counter.
//  Revision : 1.0  initial release
// ============================================================================
module adpcm_sample_sequencer #(
    parameter int NSTAGE      = 5,
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sample_strobe,
    input  logic [NSTAGE-1:0] stage_done,
    input  logic              clr_status,
    output logic [NSTAGE-1:0] stage_start,
    output logic              busy,
    output logic              sample_done,
    output logic [2:0]        cur_stage,
    output logic              overrun,
    output logic              timeout_err,
    output logic [2:0]        timeout_stage,
    output logic [CNT_W-1:0]  sample_cnt,
    input  logic              scan_in0,
    input  logic              scan_en,
    output logic              scan_out0
);

    localparam int                WD_W       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [2:0]        c_last_idx = 3'(NSTAGE - 1);
    localparam logic [WD_W-1:0]   c_wd_max   = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [NSTAGE-1:0] c_one      = NSTAGE'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_WAIT   = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [2:0]        r_idx, w_idx_nxt;
    logic [WD_W-1:0]   r_wdog, w_wdog_nxt;
    logic [NSTAGE-1:0] r_stage_start, w_stage_start_nxt;
    logic              r_busy, w_busy_nxt;
    logic              r_sample_done, w_sample_done_nxt;
    logic [2:0]        r_cur_stage, w_cur_stage_nxt;
    logic              r_overrun, w_overrun_nxt;
    logic              r_timeout_err, w_timeout_err_nxt;
    logic [2:0]        r_timeout_stage, w_timeout_stage_nxt;
    logic [CNT_W-1:0]  r_sample_cnt, w_sample_cnt_nxt;
    logic              w_adv;
    logic              w_unused_scan;

    assign w_unused_scan = scan_in0 ^ scan_en;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state         <= S_IDLE;
            r_idx           <= '0;
            r_wdog          <= '0;
            r_stage_start   <= '0;
            r_busy          <= 1'b0;
            r_sample_done   <= 1'b0;
            r_cur_stage     <= '0;
            r_overrun       <= 1'b0;
            r_timeout_err   <= 1'b0;
            r_timeout_stage <= '0;
            r_sample_cnt    <= '0;
        end else begin
            r_state         <= w_state_nxt;
            r_idx           <= w_idx_nxt;
            r_wdog          <= w_wdog_nxt;
            r_stage_start   <= w_stage_start_nxt;
            r_busy          <= w_busy_nxt;
            r_sample_done   <= w_sample_done_nxt;
            r_cur_stage     <= w_cur_stage_nxt;
            r_overrun       <= w_overrun_nxt;
            r_timeout_err   <= w_timeout_err_nxt;
            r_timeout_stage <= w_timeout_stage_nxt;
            r_sample_cnt    <= w_sample_cnt_nxt;
        end
    end

    // Every output is registered, so the next-state logic also computes the
    // value each output must show during the upcoming state.
    always_comb begin
        w_state_nxt         = r_state;
        w_idx_nxt           = r_idx;
        w_wdog_nxt          = r_wdog;
        w_stage_start_nxt   = '0;
        w_busy_nxt          = r_busy;
        w_sample_done_nxt   = 1'b0;
        w_cur_stage_nxt     = r_cur_stage;
        w_overrun_nxt       = r_overrun;
        w_timeout_err_nxt   = r_timeout_err;
        w_timeout_stage_nxt = r_timeout_stage;
        w_sample_cnt_nxt    = r_sample_cnt;
        w_adv               = 1'b0;

        if (clr_status) begin
            w_overrun_nxt       = 1'b0;
            w_timeout_err_nxt   = 1'b0;
            w_timeout_stage_nxt = '0;
        end

        if (sample_strobe && (r_state != S_IDLE)) begin
            w_overrun_nxt = 1'b1;
        end

        case (r_state)
            S_IDLE: begin
                if (sample_strobe) begin
                    w_state_nxt       = S_ISSUE;
                    w_busy_nxt        = 1'b1;
                    w_idx_nxt         = '0;
                    w_cur_stage_nxt   = '0;
                    w_stage_start_nxt = c_one;
                end
            end
            S_ISSUE: begin
                w_wdog_nxt  = '0;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // A done coinciding with the last watchdog cycle takes priority.
                if (stage_done[r_idx]) begin
                    w_adv = 1'b1;
                end else if (r_wdog == c_wd_max) begin
                    w_adv               = 1'b1;
                    w_timeout_err_nxt   = 1'b1;
                    w_timeout_stage_nxt = r_idx;
                end else begin
                    w_wdog_nxt = r_wdog + WD_W'(1);
                end

                if (w_adv) begin
                    if (r_idx == c_last_idx) begin
                        w_state_nxt       = S_FINISH;
                        w_sample_done_nxt = 1'b1;
                        w_sample_cnt_nxt  = r_sample_cnt + CNT_W'(1);
                    end else begin
                        w_state_nxt       = S_ISSUE;
                        w_idx_nxt         = r_idx + 3'd1;
                        w_cur_stage_nxt   = r_idx + 3'd1;
                        w_stage_start_nxt = c_one << (r_idx + 3'd1);
                    end
                end
            end
            S_FINISH: begin
                w_state_nxt     = S_IDLE;
                w_busy_nxt      = 1'b0;
                w_idx_nxt       = '0;
                w_cur_stage_nxt = '0;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign stage_start   = r_stage_start;
    assign busy          = r_busy;
    assign sample_done   = r_sample_done;
    assign cur_stage     = r_cur_stage;
    assign overrun       = r_overrun;
    assign timeout_err   = r_timeout_err;
    assign timeout_stage = r_timeout_stage;
    assign sample_cnt    = r_sample_cnt;
    assign scan_out0     = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_adpcm_sample_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_adpcm_sample_sequencer
//  Brief    : Directed table-driven bench for adpcm_sample_sequencer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_adpcm_sample_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       sample_strobe = 1'b0;
    logic       clr_status = 1'b0;
    logic       scan_in0 = 1'b0;
    logic       scan_en = 1'b0;
    logic [4:0] stage_done = '0;

    logic [4:0]  stage_start;
    logic        busy, sample_done, overrun, timeout_err, scan_out0;
    logic [2:0]  cur_stage, timeout_stage;
    logic [15:0] sample_cnt;

    logic [4:0]  s_stage_start;
    logic        s_busy, s_sample_done, s_overrun, s_timeout_err, s_scan_out0;
    logic [2:0]  s_cur_stage, s_timeout_stage;
    logic [2:0]  s_sample_cnt;

    adpcm_sample_sequencer #(.NSTAGE(5), .TIMEOUT_CYC(64), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .sample_strobe(sample_strobe),
        .stage_done(stage_done), .clr_status(clr_status),
        .stage_start(stage_start), .busy(busy), .sample_done(sample_done),
        .cur_stage(cur_stage), .overrun(overrun), .timeout_err(timeout_err),
        .timeout_stage(timeout_stage), .sample_cnt(sample_cnt),
        .scan_in0(scan_in0), .scan_en(scan_en), .scan_out0(scan_out0)
    );

    // Narrow counter copy so the wrap from all-ones to zero is reachable quickly.
    adpcm_sample_sequencer #(.NSTAGE(5), .TIMEOUT_CYC(64), .CNT_W(3)) dut_w (
        .clk(clk), .reset(reset), .sample_strobe(sample_strobe),
        .stage_done(stage_done), .clr_status(clr_status),
        .stage_start(s_stage_start), .busy(s_busy), .sample_done(s_sample_done),
        .cur_stage(s_cur_stage), .overrun(s_overrun), .timeout_err(s_timeout_err),
        .timeout_stage(s_timeout_stage), .sample_cnt(s_sample_cnt),
        .scan_in0(scan_in0), .scan_en(scan_en), .scan_out0(s_scan_out0)
    );

    always #5 clk = ~clk;

    typedef struct {
        int slow_stage;   // stage with a non-default done delay (-1: none)
        int slow_k;       // done delay after start for that stage (0: never)
        int junk;         // drive stage_done[4] while the slow stage waits
        int early;        // pulse the correct done bit during the issue cycle
        int strobe2_at;   // cycle of an extra strobe (0: none)
        int clr_at;       // cycle of a clr_status pulse (0: none)
        int rst_at;       // cycle of an asynchronous reset (0: none)
        int exp_lat;
        int exp_tmo;
        int exp_tmo_stage;
        int exp_ovr;
    } vec_t;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic run_sample(input vec_t v, output int lat, output int nstart,
                              output int ndone, output int busy_cyc,
                              output int order_ok, output int cur_ok);
        int cur, cs, nxt, k;
        cur = -1; cs = 0; nxt = 0;
        lat = -1; nstart = 0; ndone = 0; busy_cyc = 0; order_ok = 1; cur_ok = 1;
        sample_strobe = 1'b1;
        stage_done    = '0;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            sample_strobe = (c == v.strobe2_at);
            clr_status    = (c == v.clr_at);
            if (busy) busy_cyc++;
            if (sample_done) begin
                ndone++;
                if (lat < 0) lat = c;
            end
            if (stage_start != 5'd0) begin
                nstart++;
                if (stage_start != 5'(1 << nxt)) order_ok = 0;
                cur = nxt;
                nxt++;
                cs = c;
            end
            if (busy ? (int'(cur_stage) != cur) : (cur_stage != 3'd0)) cur_ok = 0;
            if (v.rst_at != 0 && c == v.rst_at) begin
                check("pre_reset_cur_stage", cur_stage, cur);
                check("pre_reset_overrun", overrun, 1);
                reset = 1'b0;
                #1;
                check("rst_stage_start", stage_start, 0);
                check("rst_busy", busy, 0);
                check("rst_cur_stage", cur_stage, 0);
                check("rst_overrun", overrun, 0);
                check("rst_sample_cnt", sample_cnt, 0);
                sample_strobe = 1'b0;
                clr_status    = 1'b0;
                stage_done    = '0;
                return;
            end
            stage_done = '0;
            if (cur >= 0) begin
                k = (cur == v.slow_stage) ? v.slow_k : 1;
                if (v.early != 0 && cur == v.slow_stage && c == cs) stage_done[cur] = 1'b1;
                if (k > 0 && c == cs + k) stage_done[cur] = 1'b1;
                else if (v.junk != 0 && cur == v.slow_stage && c > cs && (k == 0 || c < cs + k))
                    stage_done[4] = 1'b1;
            end
            if (lat >= 0 && c >= lat + 3) break;
        end
        sample_strobe = 1'b0;
        clr_status    = 1'b0;
        stage_done    = '0;
    endtask

    vec_t vecs[9];
    vec_t v_norm, v_rst;

    initial begin
        int lat, nstart, ndone, busy_cyc, order_ok, cur_ok;
        logic [15:0] cnt0;

        v_norm  = '{-1, 1, 0, 0, 0, 0, 0, 11, 0, 0, 0};
        vecs[0] = v_norm;
        vecs[1] = '{2, 0, 0, 0, 0, 0, 0, 74, 1, 2, 0};   // stage 2 hangs -> timeout
        vecs[2] = '{2, 64, 0, 0, 0, 0, 0, 74, 0, 0, 0};  // done on the last watchdog cycle
        vecs[3] = '{1, 4, 1, 1, 0, 0, 0, 14, 0, 0, 0};   // wrong bit + issue-cycle done ignored
        vecs[4] = '{-1, 1, 0, 0, 3, 0, 0, 11, 0, 0, 1};  // second strobe 3 cycles later
        vecs[5] = '{-1, 1, 0, 0, 11, 0, 0, 11, 0, 0, 1}; // strobe during finish cycle
        vecs[6] = '{4, 0, 0, 0, 0, 0, 0, 74, 1, 4, 0};   // last stage hangs
        vecs[7] = '{0, 3, 0, 0, 0, 0, 0, 13, 0, 0, 0};   // slow first stage
        vecs[8] = '{-1, 1, 0, 0, 5, 5, 0, 11, 0, 0, 1};  // overrun set beats clr
        v_rst   = '{3, 0, 0, 0, 5, 0, 10, 0, 0, 0, 0};

        #2;
        check("reset_stage_start", stage_start, 0);
        check("reset_busy", busy, 0);
        check("reset_sample_done", sample_done, 0);
        check("reset_cur_stage", cur_stage, 0);
        check("reset_overrun", overrun, 0);
        check("reset_timeout_err", timeout_err, 0);
        check("reset_timeout_stage", timeout_stage, 0);
        check("reset_sample_cnt", sample_cnt, 0);
        check("reset_scan_out0", scan_out0, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            clr_status = 1'b1;
            @(negedge clk);
            clr_status = 1'b0;
            cnt0 = sample_cnt;
            run_sample(vecs[i], lat, nstart, ndone, busy_cyc, order_ok, cur_ok);
            check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
            check($sformatf("v%0d_busy_cycles", i), busy_cyc, vecs[i].exp_lat);
            check($sformatf("v%0d_starts", i), nstart, 5);
            check($sformatf("v%0d_start_order", i), order_ok, 1);
            check($sformatf("v%0d_cur_stage", i), cur_ok, 1);
            check($sformatf("v%0d_sample_dones", i), ndone, 1);
            check($sformatf("v%0d_sample_cnt", i), sample_cnt, cnt0 + 16'd1);
            check($sformatf("v%0d_timeout_err", i), timeout_err, vecs[i].exp_tmo);
            check($sformatf("v%0d_timeout_stage", i), timeout_stage, vecs[i].exp_tmo_stage);
            check($sformatf("v%0d_overrun", i), overrun, vecs[i].exp_ovr);
            check($sformatf("v%0d_idle_busy", i), busy, 0);
            if (i == 4) begin
                clr_status = 1'b1;
                @(negedge clk);
                clr_status = 1'b0;
                check("clr_overrun", overrun, 0);
            end
        end

        // Reset while waiting on stage 3, then a fresh sample starts at stage 0.
        run_sample(v_rst, lat, nstart, ndone, busy_cyc, order_ok, cur_ok);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        run_sample(v_norm, lat, nstart, ndone, busy_cyc, order_ok, cur_ok);
        check("post_reset_latency", lat, 11);
        check("post_reset_start_order", order_ok, 1);
        check("post_reset_sample_cnt", sample_cnt, 1);

        // Drive the narrow counter to all-ones, then one more sample wraps it.
        for (int j = 0; j < 10 && s_sample_cnt != 3'd7; j++)
            run_sample(v_norm, lat, nstart, ndone, busy_cyc, order_ok, cur_ok);
        check("wrap_preload", s_sample_cnt, 7);
        run_sample(v_norm, lat, nstart, ndone, busy_cyc, order_ok, cur_ok);
        check("wrap_to_zero", s_sample_cnt, 0);
        check("wrap_main_cnt", sample_cnt, 8);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
